// File: rtl/chan_selector_if.sv
// Channel-selector bus: packed channel inputs and controls in, selected data and status out.
// master drives the channels/controls; slave is the selector itself.
interface chan_selector_if #(
  parameter int CH_NUM = 4,
  parameter int DW     = 2
);
  localparam int SEL_W = $clog2(CH_NUM);

  logic [CH_NUM*DW-1:0] din;
  logic [SEL_W-1:0]     sel;
  logic                 mode;
  logic                 hold;
  logic [DW-1:0]        dout;
  logic [SEL_W-1:0]     cur_ch;
  logic                 ch_tick;
  logic                 sel_err;

  modport master (
    output din, sel, mode, hold,
    input  dout, cur_ch, ch_tick, sel_err
  );

  modport slave (
    input  din, sel, mode, hold,
    output dout, cur_ch, ch_tick, sel_err
  );
endinterface

// File: rtl/chan_selector.sv
// Registered N-channel data selector: manual select or round-robin scan with a per-channel dwell.
// Provides hold/freeze, a channel-change strobe and an out-of-range select flag.
module chan_selector #(
  parameter int CH_NUM = 4,
  parameter int DW     = 2,
  parameter int DWELL  = 8
) (
  input  logic             clk,
  input  logic             rst,
  chan_selector_if.slave   bus
);
  localparam int SEL_W = $clog2(CH_NUM);
  localparam int CNT_W = $clog2(DWELL) + 1;
  localparam logic [SEL_W:0]   CH_LIM   = (SEL_W+1)'(CH_NUM);
  localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(CH_NUM - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  typedef enum logic {MANUAL = 1'b0, SCAN = 1'b1} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [SEL_W-1:0] cur_ch_reg, next_ch;
  logic [DW-1:0]    dout_reg, dout_next;
  logic             tick_reg;
  logic             err_reg, err_next;
  logic             blank;

  logic [DW-1:0] ch_data [CH_NUM];

  generate
    for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_unpack
      assign ch_data[gi] = bus.din[gi*DW +: DW];
    end
  endgenerate

  always_comb begin
    state_next = bus.mode ? SCAN : MANUAL;
    next_ch    = cur_ch_reg;
    cnt_next   = cnt_reg;
    err_next   = 1'b0;
    blank      = 1'b0;
    if (!bus.mode) begin
      cnt_next = '0;
      if ({1'b0, bus.sel} >= CH_LIM) begin
        err_next = 1'b1;
        blank    = 1'b1;
      end else begin
        next_ch = bus.sel;
      end
    end else if (state_reg == MANUAL) begin
      // Entry edge into scan: start the dwell fresh on the current channel.
      cnt_next = '0;
    end else if (cnt_reg == CNT_LAST) begin
      cnt_next = '0;
      next_ch  = (cur_ch_reg == LAST_CH) ? '0 : cur_ch_reg + SEL_W'(1);
    end else begin
      cnt_next = cnt_reg + CNT_W'(1);
    end
    dout_next = blank ? '0 : ch_data[next_ch];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= MANUAL;
      cnt_reg    <= '0;
      cur_ch_reg <= '0;
      dout_reg   <= '0;
      tick_reg   <= 1'b0;
      err_reg    <= 1'b0;
    end else if (bus.hold) begin
      tick_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      cur_ch_reg <= next_ch;
      dout_reg   <= dout_next;
      tick_reg   <= (next_ch != cur_ch_reg);
      err_reg    <= err_next;
    end
  end

  assign bus.dout    = dout_reg;
  assign bus.cur_ch  = cur_ch_reg;
  assign bus.ch_tick = tick_reg;
  assign bus.sel_err = err_reg;
endmodule

// File: tb/tb_chan_selector.sv
// Directed bench: 4ch/2b/dwell-8 instance for manual, scan, hold and collisions;
// 5ch/4b/dwell-1 instance for out-of-range select and single-cycle dwell.
module tb_chan_selector;
  logic clk = 1'b0;
  logic rst;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  chan_selector_if #(.CH_NUM(4), .DW(2)) a_if ();
  chan_selector_if #(.CH_NUM(5), .DW(4)) b_if ();

  chan_selector #(.CH_NUM(4), .DW(2), .DWELL(8)) dut_a (.clk(clk), .rst(rst), .bus(a_if.slave));
  chan_selector #(.CH_NUM(5), .DW(4), .DWELL(1)) dut_b (.clk(clk), .rst(rst), .bus(b_if.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input int dout, input int ch, input int tick, input int err);
    chk({tag, ".dout"},    32'(a_if.dout),    32'(dout));
    chk({tag, ".cur_ch"},  32'(a_if.cur_ch),  32'(ch));
    chk({tag, ".ch_tick"}, 32'(a_if.ch_tick), 32'(tick));
    chk({tag, ".sel_err"}, 32'(a_if.sel_err), 32'(err));
  endtask

  task automatic chk_b(input string tag, input int dout, input int ch, input int tick, input int err);
    chk({tag, ".dout"},    32'(b_if.dout),    32'(dout));
    chk({tag, ".cur_ch"},  32'(b_if.cur_ch),  32'(ch));
    chk({tag, ".ch_tick"}, 32'(b_if.ch_tick), 32'(tick));
    chk({tag, ".sel_err"}, 32'(b_if.sel_err), 32'(err));
  endtask

  initial begin
    int exp_ch;
    rst = 1'b1;
    a_if.din = 8'hE4; a_if.sel = 2'd0; a_if.mode = 1'b0; a_if.hold = 1'b0;
    b_if.din = 20'h5A321; b_if.sel = 3'd0; b_if.mode = 1'b0; b_if.hold = 1'b0;

    // Reset
    step(); step();
    chk_a("reset_a", 0, 0, 0, 0);
    chk_b("reset_b", 0, 0, 0, 0);
    rst = 1'b0;
    step();
    chk_a("first_manual", 0, 0, 0, 0);

    // Manual select, din E4: ch0=00 ch1=01 ch2=10 ch3=11
    a_if.sel = 2'd1; step(); chk_a("man_sel1", 1, 1, 1, 0);
    a_if.sel = 2'd2; step(); chk_a("man_sel2", 2, 2, 1, 0);
    a_if.sel = 2'd3; step(); chk_a("man_sel3", 3, 3, 1, 0);
    a_if.sel = 2'd2; step(); chk_a("man_hold2_a", 2, 2, 1, 0);
    step();                  chk_a("man_hold2_b", 2, 2, 0, 0);
    step();                  chk_a("man_hold2_c", 2, 2, 0, 0);

    // Scan wrap from channel 3: transition edge plus 7 more edges stay on 3
    a_if.sel = 2'd3; step(); chk_a("pre_scan", 3, 3, 1, 0);
    a_if.mode = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(); chk_a($sformatf("scan_dwell3_%0d", i), 3, 3, 0, 0);
    end
    step(); chk_a("scan_wrap", 0, 0, 1, 0);
    // Full round 0->1->2->3->0 over 32 edges
    for (int k = 1; k <= 32; k++) begin
      step();
      exp_ch = (k / 8) % 4;
      chk_a($sformatf("scan_round_%0d", k), exp_ch, exp_ch, (k % 8 == 0) ? 1 : 0, 0);
    end

    // Hold at dwell count 5 on channel 0
    for (int i = 0; i < 5; i++) step();
    chk_a("pre_hold", 0, 0, 0, 0);
    a_if.hold = 1'b1;
    a_if.din = 8'hE7;  // ch0=11 ch1=01 ch2=10 ch3=11
    for (int i = 0; i < 10; i++) begin
      a_if.sel = 2'(i);
      step(); chk_a($sformatf("hold_%0d", i), 0, 0, 0, 0);
    end
    a_if.hold = 1'b0;
    step(); chk_a("resume_1", 3, 0, 0, 0);
    step(); chk_a("resume_2", 3, 0, 0, 0);
    step(); chk_a("resume_adv", 1, 1, 1, 0);

    // Mode 1->0 on the dwell-expiry edge loads sel, no advance
    for (int i = 0; i < 7; i++) step();
    chk_a("pre_collide", 1, 1, 0, 0);
    a_if.mode = 1'b0; a_if.sel = 2'd3;
    step(); chk_a("mode_collide", 3, 3, 1, 0);

    // Reset mid-scan with hold asserted
    a_if.mode = 1'b1;
    step(); step(); step();
    chk_a("pre_rst_scan", 3, 3, 0, 0);
    a_if.hold = 1'b1; rst = 1'b1;
    step(); chk_a("rst_over_hold", 0, 0, 0, 0);
    rst = 1'b0; a_if.hold = 1'b0; a_if.mode = 1'b0; a_if.sel = 2'd0;

    // Out-of-range select: ch0=1 ch1=2 ch2=3 ch3=A ch4=5
    b_if.sel = 3'd3; step(); chk_b("oor_sel3", 'hA, 3, 1, 0);
    b_if.sel = 3'd6; step(); chk_b("oor_sel6", 0, 3, 0, 1);
    b_if.sel = 3'd7; step(); chk_b("oor_sel7", 0, 3, 0, 1);
    b_if.sel = 3'd4; step(); chk_b("oor_sel4", 5, 4, 1, 0);

    // DWELL=1 scan: entry edge holds, then advance every edge; sel ignored
    b_if.mode = 1'b1; b_if.sel = 3'd6;
    step(); chk_b("d1_entry", 5, 4, 0, 0);
    step(); chk_b("d1_wrap", 1, 0, 1, 0);
    step(); chk_b("d1_adv1", 2, 1, 1, 0);
    b_if.hold = 1'b1;
    step(); chk_b("d1_hold", 2, 1, 0, 0);
    b_if.hold = 1'b0;
    step(); chk_b("d1_resume", 3, 2, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/chan_selector.md
Name: chan_selector

Overview:
Parametrised N-channel, W-bit registered data selector with two modes. In manual mode a select input picks the channel. In scan mode an internal dwell counter rotates round-robin through all channels. The block drives board-level indicators (led/segment paths) from switch- or datapath-sourced channels, with a freeze control and channel-change strobe for downstream display logic.

Parameters:
CH_NUM, 4, number of input channels; legal range CH_NUM >= 2
DW, 2, data width per channel
DWELL, 8, clock cycles spent on each channel in scan mode; legal range DWELL >= 1
SEL_W, $clog2(CH_NUM), select/pointer width (localparam, derived, not overridable)
CNT_W, $clog2(DWELL)+1, dwell counter width (localparam)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous reset, active-high
din  input  CH_NUM*DW  packed channels; channel i occupies din[i*DW +: DW]
sel  input  SEL_W  manual channel select
mode  input  1  0 = manual, 1 = scan
hold  input  1  1 = freeze all state and outputs
dout  output  DW  registered selected data
cur_ch  output  SEL_W  registered index of the channel currently driven on dout
ch_tick  output  1  one-cycle pulse, asserted in the cycle cur_ch takes a new value
sel_err  output  1  registered; 1 while manual sel >= CH_NUM

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset (rst=1 at edge): dout=0, cur_ch=0, ch_tick=0, sel_err=0, dwell counter=0, state=MANUAL. rst overrides hold and mode.
- States: MANUAL, SCAN. Next state = SCAN if mode=1, else MANUAL. The state is evaluated every non-held cycle.
- All outputs are registered. next_ch is computed combinationally. On the edge: cur_ch <= next_ch and dout <= din[next_ch]. dout always corresponds to cur_ch, with 1-cycle latency from din/sel.
- MANUAL, sel < CH_NUM: next_ch = sel; sel_err <= 0; dwell counter held at 0.
- MANUAL, sel >= CH_NUM (only possible when CH_NUM is not a power of 2): cur_ch holds; dout <= 0; sel_err <= 1; ch_tick <= 0.
- SCAN: dwell counter increments each cycle. When the counter == DWELL-1, the counter <= 0 and next_ch = (cur_ch == CH_NUM-1) ? 0 : cur_ch+1. Otherwise next_ch = cur_ch. dout keeps re-sampling din[cur_ch] every cycle, so live data is tracked. sel is ignored and sel_err <= 0.
- DWELL=1: the channel advances every cycle.
- MANUAL->SCAN transition: the counter starts at 0 and scanning starts from the current cur_ch. That channel is dwelt on for a full DWELL cycles before the first advance.
- SCAN->MANUAL transition: on the first MANUAL edge cur_ch <= sel (if legal). The counter is cleared.
- ch_tick <= 1 iff the edge is not held and next_ch != cur_ch (legal update only). Otherwise ch_tick <= 0.
- hold=1: dout, cur_ch, sel_err, state and counter all keep their values; ch_tick <= 0. mode/sel changes during hold take effect on the first edge after hold drops. A scan resumes with the remaining dwell count, not restarted.
- Simultaneous mode change and dwell expiry: the mode change wins and no advance occurs.

Test Plan:
- Reset: drive rst=1 for 2 cycles with din=8'hE4 -> dout=0, cur_ch=0, ch_tick=0, sel_err=0. The first manual edge after release with sel=0 gives dout=2'b00.
- Manual select: din=8'hE4, sel stepped 0,1,2,3 one per cycle -> dout=00,01,10,11 one cycle later each. ch_tick pulses on each change. With sel held at 2 for 3 cycles, ch_tick=0 after the first.
- Scan wrap: mode=1, DWELL=8, din=8'hE4, start cur_ch=3 -> dout=11 for 8 cycles, then cur_ch=0/dout=00. ch_tick is single-cycle at the wrap. The full cycle 0->1->2->3->0 takes 32 cycles.
- Hold mid-scan: hold=1 at dwell count 5 for 10 cycles while din changes -> dout and cur_ch are frozen and ch_tick=0. After release the channel advances exactly 3 cycles later.
- Out-of-range: CH_NUM=5, DW=4, sel=3 then sel=6 -> dout=din[3], then dout=0 with sel_err=1 and cur_ch stays 3. Returning to sel=4 gives sel_err=0 and dout=din[4].
- Mode/reset collisions: a mode 1->0 change on the dwell-expiry cycle loads sel with no advance. rst asserted mid-scan while hold=1 still clears all outputs.
